// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: decode-to-execute multiply/divide bus.
//   master (execute stage): drives op, op_valid, flush, hold, src_a, src_b;
//                           receives stallreq_for_mdu, hi_we/hi_o, lo_we/lo_o, busy.
//   slave  (ex_muldiv_unit): the reverse directions.
//   op is one-hot {mult, multu, div, divu}; all-zero means no operation.
interface ex_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [3:0]       op;
  logic             op_valid;
  logic             flush;
  logic             hold;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             stallreq_for_mdu;
  logic             hi_we;
  logic [WIDTH-1:0] hi_o;
  logic             lo_we;
  logic [WIDTH-1:0] lo_o;
  logic             busy;

  modport master (
    output op, op_valid, flush, hold, src_a, src_b,
    input  stallreq_for_mdu, hi_we, hi_o, lo_we, lo_o, busy
  );

  modport slave (
    input  op, op_valid, flush, hold, src_a, src_b,
    output stallreq_for_mdu, hi_we, hi_o, lo_we, lo_o, busy
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: execute-stage iterative multiply/divide engine.
//   clk, rst : pipeline clock, asynchronous active-high reset
//   bus      : ex_muldiv_unit_if.slave
//     op/op_valid/src_a/src_b : operation issue from the decode-to-execute bus
//     flush                    : cancel any in-flight operation (beats hold)
//     hold                     : downstream stall, keeps the result on the outputs
//     stallreq_for_mdu         : stall IF/ID/EX while an operation is in flight
//     hi_we/hi_o, lo_we/lo_o   : hi/lo write toward ex_to_rf / ex_to_mem
//     busy                     : FSM not idle
// Multiply is shift-add (LSB first), divide is restoring (MSB first); both work on
// operand magnitudes and fix the signs when entering DONE. Issue at T, write at T+33.
// Optional: define MDU_FAST_MULT_EN for a single-cycle mult/multu (write at T+1).
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic              clk,
  input logic              rst,
  ex_muldiv_unit_if.slave  bus
);

  localparam int unsigned DW = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DW-1:0]      acc_q;     // mul: {hi, multiplier/lo}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   b_q;       // multiplicand magnitude or divisor magnitude
  logic               neg_q_q;   // negate product / quotient
  logic               neg_r_q;   // negate remainder (dividend sign)
  logic               b_zero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               start;
  logic               is_signed;
  logic               is_div;
  logic               last;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;

  assign start     = bus.op_valid & (|bus.op) & ~bus.flush;
  assign is_signed = bus.op[3] | bus.op[1];
  assign is_div    = bus.op[1] | bus.op[0];
  assign last      = (cnt_q == CNT_W'(WIDTH - 1));
  assign a_abs     = (is_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign b_abs     = (is_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

`ifdef MDU_FAST_MULT_EN
  logic           sext_en;
  logic [DW-1:0]  fast_prod;
  // Sign-extending to 2*WIDTH makes the truncated product correct for both signednesses.
  assign sext_en   = bus.op[3];
  assign fast_prod = {{WIDTH{sext_en & bus.src_a[WIDTH-1]}}, bus.src_a}
                   * {{WIDTH{sext_en & bus.src_b[WIDTH-1]}}, bus.src_b};
`else
  logic [WIDTH:0]  mul_sum;
  logic [DW-1:0]   mul_next;
  logic [DW-1:0]   mul_res;
  assign mul_sum  = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_res  = neg_q_q ? -mul_next : mul_next;
`endif

  // Restoring step: remainder stays below the divisor, so a (WIDTH+1)-bit subtraction's
  // top bit is the borrow. Divide by zero never borrows: quotient all ones, rem = |a|.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_borrow;
  logic [WIDTH-1:0] div_rem;
  logic [DW-1:0]    div_next;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  assign div_shift  = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff   = div_shift - {1'b0, b_q};
  assign div_borrow = div_diff[WIDTH];
  assign div_rem    = div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign div_next   = {div_rem, acc_q[WIDTH-2:0], ~div_borrow};
  assign div_hi     = neg_r_q ? -div_next[DW-1:WIDTH] : div_next[DW-1:WIDTH];
  assign div_lo     = b_zero_q ? '1
                    : (neg_q_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      b_zero_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q    <= '0;
            neg_q_q  <= is_signed & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            neg_r_q  <= is_signed & bus.src_a[WIDTH-1];
            b_zero_q <= (bus.src_b == '0);
            if (is_div) begin
              acc_q   <= {{WIDTH{1'b0}}, a_abs};
              b_q     <= b_abs;
              state_q <= StDiv;
            end else begin
`ifdef MDU_FAST_MULT_EN
              {hi_q, lo_q} <= fast_prod;
              state_q      <= StDone;
`else
              acc_q   <= {{WIDTH{1'b0}}, b_abs};
              b_q     <= a_abs;
              state_q <= StMul;
`endif
            end
          end
        end
`ifndef MDU_FAST_MULT_EN
        StMul: begin
          if (bus.flush) begin
            state_q <= StIdle;
          end else begin
            acc_q <= mul_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
              {hi_q, lo_q} <= mul_res;
              state_q      <= StDone;
            end
          end
        end
`endif
        StDiv: begin
          if (bus.flush) begin
            state_q <= StIdle;
          end else begin
            acc_q <= div_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
              hi_q    <= div_hi;
              lo_q    <= div_lo;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          // Leaving DONE goes straight to IDLE; the finished instruction exits EX here.
          if (bus.flush || !bus.hold) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy             = (state_q != StIdle);
  assign bus.stallreq_for_mdu = ((state_q == StIdle) && start)
                              || (((state_q == StMul) || (state_q == StDiv)) && !bus.flush);
  assign bus.hi_we            = (state_q == StDone) && !bus.flush;
  assign bus.lo_we            = (state_q == StDone) && !bus.flush;
  assign bus.hi_o             = hi_q;
  assign bus.lo_o             = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: hand-computed mult/div vectors, hold, flush and
// asynchronous reset behaviour. Inputs change 2 time units after the rising edge.
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.WIDTH(32)) bus ();

  ex_muldiv_unit #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [3:0] OpMult  = 4'b1000;
  localparam logic [3:0] OpMultu = 4'b0100;
  localparam logic [3:0] OpDiv   = 4'b0010;
  localparam logic [3:0] OpDivu  = 4'b0001;

  localparam int unsigned DivLat = 33;
`ifdef MDU_FAST_MULT_EN
  localparam int unsigned MulLat = 1;
  localparam logic [3:0]  RstOp  = OpDivu;
`else
  localparam int unsigned MulLat = 33;
  localparam logic [3:0]  RstOp  = OpMultu;
`endif

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called 2 units after a rising edge with the unit idle; returns likewise.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int unsigned lat);
    int unsigned stall_cnt = 0;
    int unsigned we_cnt    = 0;
    bus.op       = op;
    bus.op_valid = 1'b1;
    bus.src_a    = a;
    bus.src_b    = b;
    #1;
    if (bus.stallreq_for_mdu) stall_cnt++;
    for (int c = 1; c < lat; c++) begin
      @(posedge clk); #2;
      if (c == 1) begin
        bus.src_a = ~a;
        bus.src_b = b ^ 32'h5a5a_5a5a;
      end
      if (bus.stallreq_for_mdu) stall_cnt++;
      if (bus.hi_we || bus.lo_we) we_cnt++;
    end
    @(posedge clk); #2;
    check_eq({tag, " stall cycles"}, 64'(stall_cnt), 64'(lat));
    check_eq({tag, " early write"}, 64'(we_cnt), 64'd0);
    check_eq({tag, " we"}, {62'd0, bus.hi_we, bus.lo_we}, 64'd3);
    check_eq({tag, " stall in done"}, {63'd0, bus.stallreq_for_mdu}, 64'd0);
    check_eq({tag, " result"}, {bus.hi_o, bus.lo_o}, {exp_hi, exp_lo});
    bus.op_valid = 1'b0;
    bus.op       = 4'b0000;
    @(posedge clk); #2;
    check_eq({tag, " idle after"},
             {60'd0, bus.hi_we, bus.lo_we, bus.busy, bus.stallreq_for_mdu}, 64'd0);
  endtask

  initial begin
    int unsigned we_cnt;
    int unsigned bad;
    rst          = 1'b1;
    bus.op       = 4'b0000;
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.hold     = 1'b0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    #1;
    check_eq("reset outputs",
             {bus.hi_o, bus.lo_o} | 64'({bus.hi_we, bus.lo_we, bus.busy, bus.stallreq_for_mdu}),
             64'd0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;

    run_op("multu max",  OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MulLat);
    run_op("mult -2*3",  OpMult,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MulLat);
    run_op("mult -5*-5", OpMult,  32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0019, MulLat);
    run_op("div -7/2",   OpDiv,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DivLat);
    run_op("div 7/-2",   OpDiv,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DivLat);
    run_op("divu 100/7", OpDivu,  32'd100,       32'd7,         32'd2,         32'd14,        DivLat);
    run_op("divu by 0",  OpDivu,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, DivLat);
    run_op("div -7 by 0", OpDiv,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, DivLat);
    run_op("div min/-1", OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DivLat);

    // hold from T+30 through T+35: DONE T+33..T+36, IDLE at T+37.
    we_cnt       = 0;
    bad          = 0;
    bus.op       = OpDiv;
    bus.op_valid = 1'b1;
    bus.src_a    = 32'hFFFF_FFF9;
    bus.src_b    = 32'h0000_0002;
    for (int c = 1; c <= 36; c++) begin
      @(posedge clk); #2;
      if (c == 30) bus.hold = 1'b1;
      if (c == 36) begin
        bus.hold     = 1'b0;
        bus.op_valid = 1'b0;
        bus.op       = 4'b0000;
      end
      if (bus.hi_we) we_cnt++;
      if (c >= 33 && (!bus.hi_we || !bus.lo_we || bus.hi_o !== 32'hFFFF_FFFF
                      || bus.lo_o !== 32'hFFFF_FFFD || bus.stallreq_for_mdu)) bad++;
    end
    check_eq("hold write cycles", 64'(we_cnt), 64'd4);
    check_eq("hold output stable", 64'(bad), 64'd0);
    @(posedge clk); #2;
    check_eq("hold idle at T+37", {62'd0, bus.busy, bus.hi_we}, 64'd0);
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      if (bus.hi_we || bus.busy || bus.stallreq_for_mdu) bad++;
    end
    check_eq("hold no reissue", 64'(bad), 64'd0);

    // flush at T+10 of a div
    bus.op       = OpDivu;
    bus.op_valid = 1'b1;
    bus.src_a    = 32'd100;
    bus.src_b    = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #2;
    end
    bus.flush    = 1'b1;
    bus.op_valid = 1'b0;
    bus.op       = 4'b0000;
    #1;
    check_eq("flush same cycle", {61'd0, bus.stallreq_for_mdu, bus.hi_we, bus.lo_we}, 64'd0);
    @(posedge clk); #2;
    bus.flush = 1'b0;
    check_eq("flush to idle",
             {61'd0, bus.busy, bus.stallreq_for_mdu, bus.hi_we | bus.lo_we}, 64'd0);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #2;
      if (bus.hi_we || bus.lo_we || bus.busy) bad++;
    end
    check_eq("flush no write", 64'(bad), 64'd0);

    // asynchronous reset mid-operation
    bus.op       = RstOp;
    bus.op_valid = 1'b1;
    bus.src_a    = 32'h0000_1234;
    bus.src_b    = 32'h0000_0005;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #2;
    end
    #1;
    rst          = 1'b1;
    bus.op_valid = 1'b0;
    bus.op       = 4'b0000;
    #1;
    check_eq("async reset ctl",
             {60'd0, bus.busy, bus.stallreq_for_mdu, bus.hi_we, bus.lo_we}, 64'd0);
    check_eq("async reset data", {bus.hi_o, bus.lo_o}, 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    run_op("divu 9/3", OpDivu, 32'd9, 32'd3, 32'd0, 32'd3, DivLat);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
